// File: rtl/lock_access_ctrl.sv
// rtl/lock_access_ctrl.sv - attempt-window lock controller: timed unlock on detect, lockout with alarm after repeated failures
module lock_access_ctrl #(
  parameter int ATTEMPT_BITS   = 8,
  parameter int MAX_FAILS      = 3,
  parameter int UNLOCK_CYCLES  = 16,
  parameter int LOCKOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           din_valid,
  input  logic                           pattern_detect,
  input  logic                           relock,
  output logic                           unlock,
  output logic                           locked_out,
  output logic                           alarm,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_count
);

  localparam int FW   = $clog2(MAX_FAILS + 1);
  localparam int BW   = $clog2(ATTEMPT_BITS);
  localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [FW-1:0] MAXF     = FW'(MAX_FAILS);
  localparam logic [BW-1:0] LAST_BIT = BW'(ATTEMPT_BITS - 1);
  localparam logic [TW-1:0] T_UNLOCK = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] T_LOCKO  = TW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOCKED   = 2'd0,
    S_UNLOCKED = 2'd1,
    S_LOCKOUT  = 2'd2
  } state_t;

  state_t        r_state, w_state;
  logic [TW-1:0] r_timer, w_timer;
  logic [BW-1:0] r_bit_cnt, w_bit_cnt;
  logic [FW-1:0] r_fail, w_fail;
  logic          w_alarm;
  logic          r_unlock, r_locked_out, r_alarm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_LOCKED;
      r_timer      <= '0;
      r_bit_cnt    <= '0;
      r_fail       <= '0;
      r_unlock     <= 1'b0;
      r_locked_out <= 1'b0;
      r_alarm      <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_timer      <= w_timer;
      r_bit_cnt    <= w_bit_cnt;
      r_fail       <= w_fail;
      r_unlock     <= (w_state == S_UNLOCKED);
      r_locked_out <= (w_state == S_LOCKOUT);
      r_alarm      <= w_alarm;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_timer   = r_timer;
    w_bit_cnt = r_bit_cnt;
    w_fail    = r_fail;
    w_alarm   = 1'b0;
    case (r_state)
      S_LOCKED: begin
        // A detect wins over a window closing in the same cycle.
        if (pattern_detect) begin
          w_state   = S_UNLOCKED;
          w_timer   = T_UNLOCK;
          w_bit_cnt = '0;
          w_fail    = '0;
        end else if (din_valid) begin
          if (r_bit_cnt < LAST_BIT) begin
            w_bit_cnt = r_bit_cnt + 1'b1;
          end else begin
            w_bit_cnt = '0;
            if (r_fail + 1'b1 < MAXF) begin
              w_fail = r_fail + 1'b1;
            end else begin
              w_fail  = MAXF;
              w_state = S_LOCKOUT;
              w_timer = T_LOCKO;
              w_alarm = 1'b1;
            end
          end
        end
      end
      S_UNLOCKED: begin
        w_bit_cnt = '0;
        if (relock || r_timer == '0) begin
          w_state = S_LOCKED;
          w_timer = '0;
        end else begin
          w_timer = r_timer - 1'b1;
        end
      end
      S_LOCKOUT: begin
        w_bit_cnt = '0;
        if (r_timer == '0) begin
          w_state = S_LOCKED;
          w_fail  = '0;
        end else begin
          w_timer = r_timer - 1'b1;
        end
      end
      default: begin
        w_state   = S_LOCKED;
        w_timer   = '0;
        w_bit_cnt = '0;
        w_fail    = '0;
      end
    endcase
  end

  assign unlock     = r_unlock;
  assign locked_out = r_locked_out;
  assign alarm      = r_alarm;
  assign fail_count = r_fail;

endmodule

// File: tb/tb_lock_access_ctrl.sv
// tb/tb_lock_access_ctrl.sv - directed self-checking bench for lock_access_ctrl
module tb_lock_access_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       din_valid = 1'b0;
  logic       pattern_detect = 1'b0;
  logic       relock = 1'b0;
  logic       unlock, locked_out, alarm;
  logic [1:0] fail_count;
  int         checks = 0;
  int         errors = 0;

  lock_access_ctrl #(
    .ATTEMPT_BITS(8), .MAX_FAILS(3), .UNLOCK_CYCLES(16), .LOCKOUT_CYCLES(64)
  ) dut (
    .clk(clk), .reset(reset), .din_valid(din_valid), .pattern_detect(pattern_detect),
    .relock(relock), .unlock(unlock), .locked_out(locked_out), .alarm(alarm),
    .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are observed there too.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic din_pulses(input int n);
    din_valid = 1'b1;
    step(n);
    din_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(2);
    checks++;
    if ({unlock, locked_out, alarm, fail_count} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b expected 00000", {unlock, locked_out, alarm, fail_count});
    end
    reset = 1'b0;
    step(4);
  endtask

  task automatic test_unlock();
    pattern_detect = 1'b1;
    step(1);
    pattern_detect = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (unlock !== 1'b1 || locked_out !== 1'b0 || fail_count !== 2'd0) begin
        errors++;
        $display("FAIL unlock_window cyc %0d got unlock=%b lo=%b fc=%0d expected 1 0 0",
                 i, unlock, locked_out, fail_count);
      end
      step(1);
    end
    checks++;
    if (unlock !== 1'b0) begin
      errors++;
      $display("FAIL unlock_end got %b expected 0", unlock);
    end
  endtask

  task automatic test_single_fail();
    do_reset();
    din_pulses(7);
    checks++;
    if (fail_count !== 2'd0) begin
      errors++;
      $display("FAIL fail_before_8th got %0d expected 0", fail_count);
    end
    din_pulses(1);
    checks++;
    if (fail_count !== 2'd1 || unlock !== 1'b0) begin
      errors++;
      $display("FAIL fail_after_8th got fc=%0d unlock=%b expected 1 0", fail_count, unlock);
    end
    relock = 1'b1;
    step(1);
    relock = 1'b0;
    checks++;
    if (unlock !== 1'b0 || fail_count !== 2'd1) begin
      errors++;
      $display("FAIL relock_in_locked got unlock=%b fc=%0d expected 0 1", unlock, fail_count);
    end
  endtask

  task automatic test_lockout();
    do_reset();
    din_pulses(16);
    checks++;
    if (fail_count !== 2'd2) begin
      errors++;
      $display("FAIL fail_after_16 got %0d expected 2", fail_count);
    end
    din_pulses(7);
    checks++;
    if (alarm !== 1'b0 || locked_out !== 1'b0) begin
      errors++;
      $display("FAIL pre_lockout got alarm=%b lo=%b expected 0 0", alarm, locked_out);
    end
    din_pulses(1);
    checks++;
    if (alarm !== 1'b1 || locked_out !== 1'b1 || fail_count !== 2'd3) begin
      errors++;
      $display("FAIL lockout_entry got alarm=%b lo=%b fc=%0d expected 1 1 3", alarm, locked_out, fail_count);
    end
    for (int c = 2; c <= 64; c++) begin
      pattern_detect = (c == 10);
      din_valid      = (c == 20);
      relock         = (c == 30);
      step(1);
      checks++;
      if (locked_out !== 1'b1 || unlock !== 1'b0 || alarm !== 1'b0) begin
        errors++;
        $display("FAIL lockout_window cyc %0d got lo=%b unlock=%b alarm=%b expected 1 0 0",
                 c, locked_out, unlock, alarm);
      end
    end
    pattern_detect = 1'b0;
    din_valid = 1'b0;
    relock = 1'b0;
    step(1);
    checks++;
    if (locked_out !== 1'b0 || unlock !== 1'b0 || fail_count !== 2'd0) begin
      errors++;
      $display("FAIL lockout_exit got lo=%b unlock=%b fc=%0d expected 0 0 0", locked_out, unlock, fail_count);
    end
  endtask

  task automatic test_detect_priority();
    do_reset();
    din_pulses(15);
    checks++;
    if (fail_count !== 2'd1) begin
      errors++;
      $display("FAIL prio_setup got %0d expected 1", fail_count);
    end
    din_valid = 1'b1;
    pattern_detect = 1'b1;
    step(1);
    din_valid = 1'b0;
    pattern_detect = 1'b0;
    checks++;
    if (unlock !== 1'b1 || fail_count !== 2'd0) begin
      errors++;
      $display("FAIL prio_unlock got unlock=%b fc=%0d expected 1 0", unlock, fail_count);
    end
    step(15);
    checks++;
    if (unlock !== 1'b1) begin
      errors++;
      $display("FAIL prio_last_cycle got %b expected 1", unlock);
    end
    step(1);
    checks++;
    if (unlock !== 1'b0 || fail_count !== 2'd0) begin
      errors++;
      $display("FAIL prio_end got unlock=%b fc=%0d expected 0 0", unlock, fail_count);
    end
  endtask

  task automatic test_relock();
    do_reset();
    pattern_detect = 1'b1;
    step(1);
    pattern_detect = 1'b0;
    step(3);
    checks++;
    if (unlock !== 1'b1) begin
      errors++;
      $display("FAIL relock_4th_cycle got %b expected 1", unlock);
    end
    relock = 1'b1;
    step(1);
    relock = 1'b0;
    checks++;
    if (unlock !== 1'b0) begin
      errors++;
      $display("FAIL relock_drop got %b expected 0", unlock);
    end
    test_unlock();
  endtask

  task automatic test_reset_mid_lockout();
    do_reset();
    din_pulses(24);
    step(29);
    checks++;
    if (locked_out !== 1'b1 || fail_count !== 2'd3) begin
      errors++;
      $display("FAIL mid_lockout got lo=%b fc=%0d expected 1 3", locked_out, fail_count);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (locked_out !== 1'b0 || fail_count !== 2'd0 || alarm !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got lo=%b fc=%0d alarm=%b expected 0 0 0", locked_out, fail_count, alarm);
    end
    step(2);
    reset = 1'b0;
    step(1);
    test_unlock();
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_single_fail();
    test_lockout();
    test_detect_priority();
    test_relock();
    test_reset_mid_lockout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule
